// File: rtl/spin_pkg.sv
// Shared defaults and state encoding for the spin pulse generator.
package spin_pkg;

  localparam int unsigned DefValW      = 28;
  localparam int unsigned DefCntW      = 32;
  localparam int unsigned DefMinPeriod = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } spin_state_e;

endpackage

// File: rtl/spin_val_sync.sv
// Two-stage stability filter: target only follows val_i once it has held for two samples.
module spin_val_sync
  import spin_pkg::*;
#(
  parameter int unsigned VAL_W = DefValW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] val_i,
  output logic [VAL_W-1:0] target_o
);

  logic [VAL_W-1:0] s1_q, s2_q, target_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      target_q <= '0;
    end else begin
      s1_q <= val_i;
      s2_q <= s1_q;
      // A word still moving between samples is ignored.
      if (s1_q == s2_q) begin
        target_q <= s2_q;
      end
    end
  end

  assign target_o = target_q;

endmodule

// File: rtl/spin_pulse_gen.sv
// Square-wave spin generator: period taken from the filtered rate word, changed only at
// period boundaries, with optional slew-limited ramping between periods.
module spin_pulse_gen
  import spin_pkg::*;
#(
  parameter int unsigned VAL_W      = DefValW,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned MIN_PERIOD = DefMinPeriod,
  parameter int unsigned RAMP_STEP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] val_i,
  input  logic             enable_i,
  output logic             pulse_o,
  output logic             active_o,
  output logic [VAL_W-1:0] period_o,
  output logic             update_o,
  output logic [CNT_W-1:0] pulse_cnt_o
);

  localparam logic [VAL_W-1:0] MinP = VAL_W'(MIN_PERIOD);
  localparam logic [VAL_W-1:0] Step = VAL_W'(RAMP_STEP);

  spin_state_e      state_q, state_d;
  logic [VAL_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic             pulse_q, pulse_d;
  logic             update_q, update_d;
  logic [VAL_W-1:0] target, eff, diff, ramp_period;

  spin_val_sync #(
    .VAL_W (VAL_W)
  ) u_val_sync (
    .clk      (clk),
    .rst      (rst),
    .val_i    (val_i),
    .target_o (target)
  );

  always_comb begin
    eff = '0;
    if (target != '0) begin
      eff = (target < MinP) ? MinP : target;
    end
  end

  // Period to adopt at the next boundary, slew-limited when a ramp step is configured.
  always_comb begin
    diff        = '0;
    ramp_period = eff;
    if (RAMP_STEP != 0) begin
      if (eff > period_q) begin
        diff        = eff - period_q;
        ramp_period = period_q + ((diff > Step) ? Step : diff);
      end else begin
        diff        = period_q - eff;
        ramp_period = period_q - ((diff > Step) ? Step : diff);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    pulse_cnt_d = pulse_cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable_i && (eff != '0)) begin
          state_d  = StRun;
          period_d = eff;
        end
      end
      StRun: begin
        if (cnt_q == period_q - 1'b1) begin
          cnt_d       = '0;
          pulse_cnt_d = pulse_cnt_q + 1'b1;
          // Stop takes priority over any pending period change.
          if (!enable_i || (eff == '0)) begin
            state_d  = StIdle;
            period_d = '0;
          end else begin
            period_d = ramp_period;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        cnt_d    = '0;
        period_d = '0;
      end
    endcase
    pulse_d  = (state_d == StRun) && (cnt_d < (period_d >> 1));
    update_d = (period_d != period_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      period_q    <= '0;
      pulse_cnt_q <= '0;
      pulse_q     <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      pulse_cnt_q <= pulse_cnt_d;
      pulse_q     <= pulse_d;
      update_q    <= update_d;
    end
  end

  assign pulse_o     = pulse_q;
  assign active_o    = (state_q == StRun);
  assign period_o    = period_q;
  assign update_o    = update_q;
  assign pulse_cnt_o = pulse_cnt_q;

endmodule

// File: tb/tb_spin_pulse_gen.sv
// Directed bench for spin_pulse_gen: a jump-mode instance and a ramping instance (step 2).
module tb_spin_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] val, val_r;
  logic        enable, en_r;
  logic        pulse, active, update;
  logic        pulse_r, active_r, update_r;
  logic [27:0] period, period_r;
  logic [31:0] pulse_cnt, pulse_cnt_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spin_pulse_gen #(
    .RAMP_STEP (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .val_i       (val),
    .enable_i    (enable),
    .pulse_o     (pulse),
    .active_o    (active),
    .period_o    (period),
    .update_o    (update),
    .pulse_cnt_o (pulse_cnt)
  );

  spin_pulse_gen #(
    .RAMP_STEP (2)
  ) dut_r (
    .clk         (clk),
    .rst         (rst),
    .val_i       (val_r),
    .enable_i    (en_r),
    .pulse_o     (pulse_r),
    .active_o    (active_r),
    .period_o    (period_r),
    .update_o    (update_r),
    .pulse_cnt_o (pulse_cnt_r)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks n cycles of a running wave of period p, starting at phase start.
  task automatic chk_wave(input bit sel, input int p, input int start, input int n);
    int ph;
    for (int i = 0; i < n; i++) begin
      ph = (start + i) % p;
      check_val("pulse", 32'(sel ? pulse_r : pulse), 32'(ph < p / 2));
      check_val("period", 32'(sel ? period_r : period), 32'(p));
      check_val("active", 32'(sel ? active_r : active), 32'd1);
      if (ph != 0) check_val("update_off_boundary", 32'(sel ? update_r : update), 32'd0);
      tick();
    end
  endtask

  initial begin
    rst    = 1'b1;
    val    = 28'd8;
    enable = 1'b1;
    val_r  = 28'd0;
    en_r   = 1'b0;
    repeat (3) tick();
    check_val("rst_pulse", 32'(pulse), 32'd0);
    check_val("rst_active", 32'(active), 32'd0);
    check_val("rst_period", 32'(period), 32'd0);
    check_val("rst_update", 32'(update), 32'd0);
    check_val("rst_cnt", pulse_cnt, 32'd0);

    // 1: start at period 8 after three filter edges plus the FSM edge
    rst = 1'b0;
    repeat (3) tick();
    check_val("t1_still_idle", 32'(active), 32'd0);
    tick();
    check_val("t1_update", 32'(update), 32'd1);
    check_val("t1_period", 32'(period), 32'd8);
    chk_wave(1'b0, 8, 0, 16);
    check_val("t1_cnt", pulse_cnt, 32'd2);

    // 4: word changing every cycle never reaches target
    for (int i = 0; i < 16; i++) begin
      val = i[0] ? 28'd9 : 28'd5;
      check_val("t4_period", 32'(period), 32'd8);
      check_val("t4_update", 32'(update), 32'd0);
      check_val("t4_pulse", 32'(pulse), 32'((i % 8) < 4));
      tick();
    end
    val = 28'd8;
    check_val("t4_cnt", pulse_cnt, 32'd4);

    // 3: mid-period change to 12 waits for the boundary
    chk_wave(1'b0, 8, 0, 3);
    val = 28'd12;
    chk_wave(1'b0, 8, 3, 5);
    check_val("t3_update", 32'(update), 32'd1);
    check_val("t3_period", 32'(period), 32'd12);
    check_val("t3_cnt_a", pulse_cnt, 32'd5);
    chk_wave(1'b0, 12, 0, 12);
    check_val("t3_cnt_b", pulse_cnt, 32'd6);

    // 2: val 2 clamps to 4, then val 0 stops at the boundary
    val = 28'd2;
    chk_wave(1'b0, 12, 0, 12);
    check_val("t2_period", 32'(period), 32'd4);
    check_val("t2_update", 32'(update), 32'd1);
    chk_wave(1'b0, 4, 0, 8);
    check_val("t2_cnt_a", pulse_cnt, 32'd9);
    val = 28'd0;
    chk_wave(1'b0, 4, 0, 4);
    check_val("t2_idle_active", 32'(active), 32'd0);
    check_val("t2_idle_period", 32'(period), 32'd0);
    check_val("t2_idle_pulse", 32'(pulse), 32'd0);
    check_val("t2_cnt_b", pulse_cnt, 32'd10);

    // 5: enable drop mid-period completes the period
    val = 28'd8;
    repeat (4) tick();
    check_val("t5_period", 32'(period), 32'd8);
    check_val("t5_update", 32'(update), 32'd1);
    chk_wave(1'b0, 8, 0, 2);
    enable = 1'b0;
    chk_wave(1'b0, 8, 2, 6);
    check_val("t5_idle_active", 32'(active), 32'd0);
    check_val("t5_idle_period", 32'(period), 32'd0);
    check_val("t5_idle_pulse", 32'(pulse), 32'd0);
    check_val("t5_cnt", pulse_cnt, 32'd11);
    repeat (3) tick();
    check_val("t5_stay_idle", 32'(active), 32'd0);
    enable = 1'b1;
    tick();
    check_val("t5_restart", 32'(period), 32'd8);
    chk_wave(1'b0, 8, 0, 4);
    val = 28'd12;
    chk_wave(1'b0, 8, 4, 3);
    enable = 1'b0;
    tick();
    check_val("t5_stop_wins_active", 32'(active), 32'd0);
    check_val("t5_stop_wins_period", 32'(period), 32'd0);
    check_val("t5_stop_cnt", pulse_cnt, 32'd12);

    // 6: ramp 20 -> 10 in steps of 2, then reset mid-high
    val_r = 28'd20;
    en_r  = 1'b1;
    repeat (4) tick();
    check_val("t6_start_period", 32'(period_r), 32'd20);
    check_val("t6_start_update", 32'(update_r), 32'd1);
    val_r = 28'd10;
    chk_wave(1'b1, 20, 0, 20);
    for (int p = 18; p >= 10; p -= 2) begin
      check_val("t6_ramp_period", 32'(period_r), 32'(p));
      check_val("t6_ramp_update", 32'(update_r), 32'd1);
      chk_wave(1'b1, p, 0, p);
    end
    check_val("t6_settled_period", 32'(period_r), 32'd10);
    check_val("t6_settled_update", 32'(update_r), 32'd0);
    check_val("t6_cnt", pulse_cnt_r, 32'd6);
    repeat (2) tick();
    check_val("t6_mid_high", 32'(pulse_r), 32'd1);
    rst = 1'b1;
    tick();
    check_val("t6_rst_pulse", 32'(pulse_r), 32'd0);
    check_val("t6_rst_active", 32'(active_r), 32'd0);
    check_val("t6_rst_period", 32'(period_r), 32'd0);
    check_val("t6_rst_update", 32'(update_r), 32'd0);
    check_val("t6_rst_cnt", pulse_cnt_r, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
